debounced_pulse_bank: RTL and testbench
=======================================

Name: debounced_pulse_bank

Overview:
- Multi-channel successor to the single-bit level-to-pulse converter used for push-buttons.
- Each of CHANNELS raw button levels passes through three stages in order: 2-FF synchroniser, counter-based debouncer, edge detector.
- The edge detector mode is run-time selectable (rising, falling, both or none), with optional auto-repeat while a button is held.
- Sits between board pins and the control FSMs; each output is a clean, registered one-cycle pulse per event.

Parameters:
- CHANNELS, 4, number of independent button channels (>=1).
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles needed to accept a new level (>=1; 5 ms at 50 MHz).
- REPEAT_DELAY, 25000000, cycles from accepted press to first repeat pulse (>=1).
- REPEAT_PERIOD, 5000000, cycles between later repeat pulses (>=1).
- Counter widths are $clog2 of each count; no other width parameters.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- L  in  CHANNELS  raw asynchronous button levels; 1 = pressed.
- mode  in  2  edge select, common to all channels: 00 rising, 01 falling, 10 both, 11 none.
- repeat_en  in  1  1 = auto-repeat enabled on all channels.
- P  out  CHANNELS  registered one-cycle event pulses.
- level  out  CHANNELS  debounced stable level per channel.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - clears sync flops, stable level, debounce counters, repeat counters;
  - every channel FSM goes to IDLE;
  - P=0 and level=0 immediately, held until the first clk edge after reset_n rises.
- Sync: L[i] -> s0 -> s1, one flop each edge; the debouncer uses s1 only.
- Debounce, per channel, at each edge:
  - if s1==stable, cnt<=0;
  - else if cnt==DEBOUNCE_CYCLES-1, stable<=s1 and cnt<=0 (the accept edge);
  - else cnt<=cnt+1.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count; stable never changes for it.
- Latency: if L changes between edges E0 and E1 and then holds, stable and level flip at edge E(2+DEBOUNCE_CYCLES).
- Edge pulse: at an accept edge, P[i]<=1 for exactly one cycle if the change matches mode, sampled on that same edge.
  - Rising accepted when mode=00 or 10; falling when mode=01 or 10.
  - mode=11 gives no edge pulses.
- Repeat FSM per channel, states IDLE, HELD_DELAY, HELD_REPEAT. rcnt is the repeat counter.
  - IDLE->HELD_DELAY, rcnt<=0, on any edge where repeat_en=1 and the post-update stable=1. This covers the accept edge itself and re-enabling repeat_en mid-hold.
  - HELD_DELAY: rcnt++ each edge. When rcnt==REPEAT_DELAY-1: P[i]<=1, rcnt<=0, go to HELD_REPEAT.
  - HELD_REPEAT: rcnt++ each edge. When rcnt==REPEAT_PERIOD-1: P[i]<=1, rcnt<=0.
  - So with press accepted at edge S, repeat pulses occur at S+REPEAT_DELAY, then S+REPEAT_DELAY+k*REPEAT_PERIOD.
  - From either HELD state, go to IDLE (rcnt<=0) at the edge where stable falls or repeat_en=0 is sampled. No repeat pulse is issued on that edge.
  - Repeat pulses are independent of mode, including mode=11.
- Output combining and timing:
  - P[i] = edge-pulse OR repeat-pulse, registered.
  - An accept edge and a due repeat pulse cannot coincide except on release; the release suppresses the repeat, and only the falling-edge pulse (if the mode selects it) is emitted.
  - P is otherwise 0; there is no combinational path from L, mode or repeat_en to P.
- Independence: channels share nothing except mode, repeat_en, clk and reset_n. Several P bits may be high in the same cycle.
- L already high at reset release: stable starts 0, so a rising acceptance, and the corresponding pulse, occurs after the normal latency.
- Reset mid-debounce or mid-repeat: all progress is lost; no pulse is emitted after reset_n rises until a new acceptance.

Test Plan:
- Bench parameters: CHANNELS=4, DEBOUNCE=4, DELAY=8, PERIOD=3.
- Rising edge: mode=00, repeat_en=0, L[0] 0->1 between E0 and E1 -> level[0]=1 and P[0]=1 for one cycle at E6; P[3:1]=0 throughout.
- Glitch reject: L[1] high for 3 cycles, then low -> level[1] stays 0 and P[1] never asserts. Then hold 4+ cycles -> acceptance at E(2+4).
- Modes: toggle L[2] press/release under mode=01, 10 and 11 -> pulses on release only; on both edges; none at all, while level[2] still tracks.
- Auto-repeat: repeat_en=1, hold L[0] from accept edge S -> P[0] pulses at S, S+8, S+11, S+14. Release -> no further pulses, FSM back to IDLE.
- Simultaneity and reset:
  - L[0] and L[3] pressed in the same cycle -> P[0] and P[3] high in the same cycle.
  - reset_n=0 asserted during HELD_REPEAT -> P and level go to 0 immediately; no pulse until the next full acceptance.

Source files
------------

// File: rtl/debounced_pulse_bank.sv
// Multi-channel button front end: per-channel 2-FF synchroniser, counter debouncer,
// mode-selectable edge pulse and optional auto-repeat, merged into registered pulses.
module debounced_pulse_bank #(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] L,
  input  logic [1:0]          mode,
  input  logic                repeat_en,
  output logic [CHANNELS-1:0] P,
  output logic [CHANNELS-1:0] level
);

  localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned R_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RC_W  = (R_MAX > 1) ? $clog2(R_MAX) : 1;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RC_W-1:0] RD_LAST = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0] RP_LAST = RC_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HELD_DELAY  = 2'd1,
    HELD_REPEAT = 2'd2
  } rpt_state_e;

  logic [CHANNELS-1:0] s0;
  logic [CHANNELS-1:0] s1;
  logic                rise_en;
  logic                fall_en;

  // Two-flop synchroniser for the raw pin levels
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0 <= '0;
      s1 <= '0;
    end else begin
      s0 <= L;
      s1 <= s0;
    end
  end

  always_comb begin
    rise_en = (mode == 2'b00) || (mode == 2'b10);
    fall_en = (mode == 2'b01) || (mode == 2'b10);
  end

  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
    logic [DB_W-1:0] cnt;
    logic [RC_W-1:0] rcnt;
    logic            stable_q;
    logic            pulse_q;
    rpt_state_e      state;
    logic            accept;
    logic            stable_nxt;
    logic            edge_pulse;

    // Accept decision and the level the debouncer will hold after this edge
    always_comb begin
      accept     = (s1[i] != stable_q) && (cnt == DB_LAST);
      stable_nxt = accept ? s1[i] : stable_q;
      edge_pulse = accept && ((s1[i] && rise_en) || (!s1[i] && fall_en));
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt      <= '0;
        rcnt     <= '0;
        stable_q <= 1'b0;
        pulse_q  <= 1'b0;
        state    <= IDLE;
      end else begin
        if ((s1[i] == stable_q) || accept) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + DB_W'(1);
        end
        stable_q <= stable_nxt;
        pulse_q  <= edge_pulse;

        // Repeat FSM keys off the post-update level, so release suppresses a due repeat
        case (state)
          IDLE: begin
            if (repeat_en && stable_nxt) begin
              state <= HELD_DELAY;
              rcnt  <= '0;
            end
          end
          HELD_DELAY: begin
            if (!repeat_en || !stable_nxt) begin
              state <= IDLE;
              rcnt  <= '0;
            end else if (rcnt == RD_LAST) begin
              pulse_q <= 1'b1;
              rcnt    <= '0;
              state   <= HELD_REPEAT;
            end else begin
              rcnt <= rcnt + RC_W'(1);
            end
          end
          HELD_REPEAT: begin
            if (!repeat_en || !stable_nxt) begin
              state <= IDLE;
              rcnt  <= '0;
            end else if (rcnt == RP_LAST) begin
              pulse_q <= 1'b1;
              rcnt    <= '0;
            end else begin
              rcnt <= rcnt + RC_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            rcnt  <= '0;
          end
        endcase
      end
    end

    assign P[i]     = pulse_q;
    assign level[i] = stable_q;
  end

endmodule

// File: tb/tb_debounced_pulse_bank.sv
// Bench for debounced_pulse_bank: table-driven edge/mode vectors plus hand sequences,
// with expected pulses queued per clock edge and compared by a per-edge monitor.
module tb_debounced_pulse_bank;

  localparam int unsigned CH  = 4;
  localparam int          DB  = 4;
  localparam int          DLY = 8;
  localparam int          PER = 3;
  localparam int          LAT = 2 + DB;

  logic          clk;
  logic          reset_n;
  logic [CH-1:0] L;
  logic [1:0]    mode;
  logic          repeat_en;
  logic [CH-1:0] P;
  logic [CH-1:0] level;

  debounced_pulse_bank #(
    .CHANNELS        (CH),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (DLY),
    .REPEAT_PERIOD   (PER)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .L         (L),
    .mode      (mode),
    .repeat_en (repeat_en),
    .P         (P),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic        val;
    logic [1:0]  md;
    logic        rep;
    logic [3:0]  p;
    logic [3:0]  lvl;
  } vec_t;

  typedef struct {
    int         edge_no;
    logic [3:0] p;
    logic [3:0] lvl;
  } exp_t;

  exp_t q[$];
  vec_t tbl[8];
  int   edge_n = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0h want=%0h", nm, edge_n, act, want);
    end
  endtask

  task automatic push(input int e, input logic [3:0] p, input logic [3:0] lvl);
    exp_t x;
    x.edge_no = e;
    x.p       = p;
    x.lvl     = lvl;
    q.push_back(x);
  endtask

  always @(posedge clk) edge_n <= edge_n + 1;

  // Compare at every edge: queued edges check P and level, all others require P=0
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (q.size() > 0 && q[0].edge_no == edge_n) begin
        exp_t e;
        e = q.pop_front();
        check("pulse", 32'(P), 32'(e.p));
        check("level", 32'(level), 32'(e.lvl));
      end else begin
        check("idle_p", 32'(P), 32'd0);
      end
    end
  end

  initial begin
    int s;
    int r;

    tbl[0] = '{0, 1'b1, 2'b00, 1'b0, 4'b0001, 4'b0001};
    tbl[1] = '{0, 1'b0, 2'b00, 1'b0, 4'b0000, 4'b0000};
    tbl[2] = '{2, 1'b1, 2'b01, 1'b0, 4'b0000, 4'b0100};
    tbl[3] = '{2, 1'b0, 2'b01, 1'b0, 4'b0100, 4'b0000};
    tbl[4] = '{2, 1'b1, 2'b10, 1'b0, 4'b0100, 4'b0100};
    tbl[5] = '{2, 1'b0, 2'b10, 1'b0, 4'b0100, 4'b0000};
    tbl[6] = '{2, 1'b1, 2'b11, 1'b0, 4'b0000, 4'b0100};
    tbl[7] = '{2, 1'b0, 2'b11, 1'b0, 4'b0000, 4'b0000};

    reset_n   = 1'b0;
    L         = '0;
    mode      = 2'b00;
    repeat_en = 1'b0;
    #1;
    check("reset_p", 32'(P), 32'd0);
    check("reset_level", 32'(level), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    repeat (2) @(negedge clk);

    // Table: single press/release per entry, acceptance LAT edges after the drive edge
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      mode        = tbl[k].md;
      repeat_en   = tbl[k].rep;
      L[tbl[k].ch] = tbl[k].val;
      push(edge_n + LAT, tbl[k].p, tbl[k].lvl);
      repeat (8) @(negedge clk);
    end

    // Glitch of DB-1 cycles must be ignored, then a long hold is accepted
    mode = 2'b00;
    L[1] = 1'b1;
    repeat (DB - 1) @(negedge clk);
    L[1] = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_level", 32'(level), 32'd0);
    L[1] = 1'b1;
    push(edge_n + LAT, 4'b0010, 4'b0010);
    repeat (8) @(negedge clk);
    L[1] = 1'b0;
    push(edge_n + LAT, 4'b0000, 4'b0000);
    repeat (8) @(negedge clk);

    // Auto-repeat; release lands on a due repeat edge, which must be suppressed
    repeat_en = 1'b1;
    L[0]      = 1'b1;
    s         = edge_n + LAT;
    push(s, 4'b0001, 4'b0001);
    push(s + DLY, 4'b0001, 4'b0001);
    push(s + DLY + PER, 4'b0001, 4'b0001);
    push(s + DLY + 2 * PER, 4'b0001, 4'b0001);
    push(s + DLY + 3 * PER, 4'b0001, 4'b0001);
    push(s + DLY + 4 * PER, 4'b0000, 4'b0000);
    repeat (LAT + DLY + 2 * PER) @(negedge clk);
    L[0] = 1'b0;
    repeat (14) @(negedge clk);
    repeat_en = 1'b0;

    // Two channels accepted on the same edge
    L = 4'b1001;
    push(edge_n + LAT, 4'b1001, 4'b1001);
    repeat (8) @(negedge clk);
    L = 4'b0000;
    push(edge_n + LAT, 4'b0000, 4'b0000);
    repeat (8) @(negedge clk);

    // Reset while a repeat pulse is showing, with the button still held
    repeat_en = 1'b1;
    L[0]      = 1'b1;
    s         = edge_n + LAT;
    push(s, 4'b0001, 4'b0001);
    push(s + DLY, 4'b0001, 4'b0001);
    repeat (LAT + DLY) @(negedge clk);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("async_rst_p", 32'(P), 32'd0);
    check("async_rst_level", 32'(level), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    r       = edge_n;
    mon_en  = 1'b1;
    push(r + LAT, 4'b0001, 4'b0001);
    push(r + LAT + DLY, 4'b0001, 4'b0001);
    repeat (LAT + DLY) @(negedge clk);
    repeat_en = 1'b0;
    L[0]      = 1'b0;
    push(edge_n + LAT, 4'b0000, 4'b0000);
    repeat (12) @(negedge clk);

    check("queue_drain", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout edge=%0d got=running want=finished", edge_n);
    $fatal(1);
  end

endmodule
